// File: rtl/io_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_display_pkg
//  Description : Shared types and constants for the BCD display path.
//                - FSM state enum for the converter
//                - BCD digit count
//                - Active-low seven-segment codes ({g,f,e,d,c,b,a})
//                - Double-dabble adjust and leading-digit helpers
//  Revision    : 1.0 - initial release
// ============================================================================
package io_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ten digits hold any 32-bit unsigned magnitude (max 4294967295).
    localparam int BCD_DIGITS = 10;

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_MINUS = 7'b0111111;

    // Entry [d] is the code for decimal digit d.
    localparam logic [9:0][6:0] c_SEG_DIGITS = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Add 3 to every nibble that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [4*BCD_DIGITS-1:0] add3_adjust(input logic [4*BCD_DIGITS-1:0] v);
        logic [4*BCD_DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Index of the most significant nonzero digit; zero reports index 0 so
    // that the value 0 still counts as one digit.
    function automatic logic [3:0] msd_index(input logic [4*BCD_DIGITS-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd0) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage : io_display_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : One BCD digit to an active-low seven-segment code.
//                Minus has priority over blank, blank over the digit.
//  Ports       : digit  in  4  BCD digit 0..9 (others render blank)
//                blank  in  1  show all segments off
//                minus  in  1  show only segment g
//                seg    out 7  {g,f,e,d,c,b,a}, active low
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import io_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    always_comb begin
        seg = c_SEG_BLANK;
        if (minus) begin
            seg = c_SEG_MINUS;
        end else if (!blank && (digit <= 4'd9)) begin
            seg = c_SEG_DIGITS[digit];
        end
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/bcd_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_driver
//  Description : Sequential double-dabble conversion of a 32-bit word to ten
//                BCD digits, signed or unsigned, with leading-zero blanking,
//                minus-sign placement and overflow indication on a bank of
//                seven-segment displays.
//  Ports       : clock        in   1    system clock, rising edge
//                reset_n      in   1    asynchronous active-low reset
//                start        in   1    convert request (one cycle)
//                data         in   32   value to convert
//                signed_mode  in   1    data is two's complement
//                busy         out  1    conversion in progress
//                done         out  1    one-cycle pulse, results updated
//                bcd          out  40   ten BCD digits, [3:0] = units
//                negative     out  1    sign of the last converted value
//                overflow     out  1    value plus sign exceed the displays
//                seg          out  7*N  active-low segments, display 0 right
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_driver
    import io_display_pkg::*;
#(
    parameter int N_DISPLAYS = 8
)
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [31:0]             data,
    input  logic                    signed_mode,
    output logic                    busy,
    output logic                    done,
    output logic [39:0]             bcd,
    output logic                    negative,
    output logic                    overflow,
    output logic [7*N_DISPLAYS-1:0] seg
);

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_mag;
    logic        r_neg;
    logic [39:0] r_scratch;
    logic [4:0]  r_step;

    logic        r_pend_valid;
    logic [31:0] r_pend_data;
    logic        r_pend_signed;

    logic        r_done;
    logic [39:0] r_bcd;
    logic        r_negative;
    logic        r_overflow;

    logic        w_load;
    logic [31:0] w_load_data;
    logic        w_load_signed;
    logic        w_load_neg;
    logic [31:0] w_load_mag;
    logic [39:0] w_adj;
    logic [3:0]  w_conv_msd;
    logic        w_conv_ovf;
    logic [3:0]  w_disp_msd;

    // A new conversion starts from IDLE on start, or straight out of DONE
    // when a request arrives on that edge or one is waiting in the slot.
    // A request on the DONE edge is newer than the slot, so it wins.
    assign w_load        = ((r_state == ST_IDLE) && start) ||
                           ((r_state == ST_DONE) && (start || r_pend_valid));
    assign w_load_data   = ((r_state == ST_DONE) && !start) ? r_pend_data   : data;
    assign w_load_signed = ((r_state == ST_DONE) && !start) ? r_pend_signed : signed_mode;
    assign w_load_neg    = w_load_signed & w_load_data[31];
    // Unsigned negate: 0x80000000 maps to magnitude 2147483648 without wrap.
    assign w_load_mag    = w_load_neg ? (~w_load_data + 32'd1) : w_load_data;

    assign w_adj         = add3_adjust(r_scratch);

    assign w_conv_msd    = msd_index(r_scratch);
    assign w_conv_ovf    = ({28'd0, w_conv_msd} + 32'd1 + {31'd0, r_neg}) > 32'(N_DISPLAYS);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_CONV;
            ST_CONV: if (r_step == 5'd31) w_state_next = ST_DONE;
            ST_DONE: w_state_next = (start || r_pend_valid) ? ST_CONV : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, pending slot and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mag         <= '0;
            r_neg         <= 1'b0;
            r_scratch     <= '0;
            r_step        <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_data   <= '0;
            r_pend_signed <= 1'b0;
            r_done        <= 1'b0;
            r_bcd         <= '0;
            r_negative    <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_load) begin
                r_mag     <= w_load_mag;
                r_neg     <= w_load_neg;
                r_scratch <= '0;
                r_step    <= '0;
            end else if (r_state == ST_CONV) begin
                {r_scratch, r_mag} <= {w_adj, r_mag} << 1;
                r_step             <= r_step + 5'd1;
            end

            // Requests during CONV park in the slot (newest wins); the DONE
            // edge always consumes whatever is pending.
            if ((r_state == ST_CONV) && start) begin
                r_pend_valid  <= 1'b1;
                r_pend_data   <= data;
                r_pend_signed <= signed_mode;
            end else if (r_state == ST_DONE) begin
                r_pend_valid  <= 1'b0;
            end

            r_done <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_bcd      <= r_scratch;
                r_negative <= r_neg;
                r_overflow <= w_conv_ovf;
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign negative = r_negative;
    assign overflow = r_overflow;

    // ------------------------------------------------------------------
    // Display mapping, driven only by the registered results
    // ------------------------------------------------------------------
    assign w_disp_msd = msd_index(r_bcd);

    for (genvar k = 0; k < N_DISPLAYS; k++) begin : g_disp
        localparam logic [4:0] c_POS = 5'(k);
        logic w_blank;
        logic w_minus;

        assign w_blank = c_POS > {1'b0, w_disp_msd};
        assign w_minus = r_overflow |
                         (r_negative && (c_POS == ({1'b0, w_disp_msd} + 5'd1)));

        seg7_decode u_seg7 (
            .digit (r_bcd[4*k +: 4]),
            .blank (w_blank),
            .minus (w_minus),
            .seg   (seg[7*k +: 7])
        );
    end

endmodule : bcd_display_driver
`default_nettype wire

// File: tb/tb_bcd_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_display_driver
//  Description : Directed self-checking bench. Two instances share inputs:
//                one with 8 displays, one with 10.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_driver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] data;
    logic        signed_mode;

    logic        busy8, done8, neg8, ovf8;
    logic [39:0] bcd8;
    logic [55:0] seg8;
    logic        busy10, done10, neg10, ovf10;
    logic [39:0] bcd10;
    logic [69:0] seg10;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    bcd_display_driver #(.N_DISPLAYS(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start), .data(data),
        .signed_mode(signed_mode), .busy(busy8), .done(done8), .bcd(bcd8),
        .negative(neg8), .overflow(ovf8), .seg(seg8)
    );

    bcd_display_driver #(.N_DISPLAYS(10)) dut10 (
        .clock(clock), .reset_n(reset_n), .start(start), .data(data),
        .signed_mode(signed_mode), .busy(busy10), .done(done10), .bcd(bcd10),
        .negative(neg10), .overflow(ovf10), .seg(seg10)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the edge that samples the request.
    task automatic start_req(input logic [31:0] d, input logic sm);
        @(negedge clock);
        data        = d;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Request at edge t; returns just after edge t+33 with done checked.
    task automatic run_conv(input logic [31:0] d, input logic sm, input string tag);
        start_req(d, sm);
        wait_edges(32);
        check({tag, " done before t+33"}, 70'(done8), 70'(1'b0));
        check({tag, " busy at t+32"},     70'(busy8), 70'(1'b1));
        wait_edges(1);
        check({tag, " done at t+33"},     70'(done8), 70'(1'b1));
        check({tag, " done10 at t+33"},   70'(done10), 70'(1'b1));
    endtask

    task automatic end_conv(input string tag);
        wait_edges(1);
        check({tag, " done drops"}, 70'(done8), 70'(1'b0));
        check({tag, " busy drops"}, 70'(busy8), 70'(1'b0));
    endtask

    initial begin
        logic [31:0] d;
        logic        bad;

        reset_n     = 1'b0;
        start       = 1'b0;
        data        = '0;
        signed_mode = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        wait_edges(3);

        // Reset state
        check("rst busy",  70'(busy8), 70'(1'b0));
        check("rst done",  70'(done8), 70'(1'b0));
        check("rst bcd",   70'(bcd8),  70'(40'h0));
        check("rst neg",   70'(neg8),  70'(1'b0));
        check("rst ovf",   70'(ovf8),  70'(1'b0));
        check("rst seg8",  70'(seg8),  70'({{7{7'h7F}}, 7'h40}));

        // 12345 unsigned
        run_conv(32'd12345, 1'b0, "12345");
        check("12345 bcd",  70'(bcd8), 70'(40'h0000012345));
        check("12345 neg",  70'(neg8), 70'(1'b0));
        check("12345 ovf",  70'(ovf8), 70'(1'b0));
        check("12345 seg8", 70'(seg8),
              70'({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));
        end_conv("12345");

        // -1 signed
        run_conv(32'hFFFFFFFF, 1'b1, "m1");
        check("m1 bcd",  70'(bcd8), 70'(40'h1));
        check("m1 neg",  70'(neg8), 70'(1'b1));
        check("m1 ovf",  70'(ovf8), 70'(1'b0));
        check("m1 seg8", 70'(seg8), 70'({{6{7'h7F}}, 7'h3F, 7'h79}));
        end_conv("m1");

        // -40 signed: minus two places left of units
        run_conv(32'hFFFFFFD8, 1'b1, "m40");
        check("m40 bcd",  70'(bcd8), 70'(40'h40));
        check("m40 seg8", 70'(seg8), 70'({{5{7'h7F}}, 7'h3F, 7'h19, 7'h40}));
        end_conv("m40");

        // 4294967295 unsigned: 10 digits overflow 8 displays, fit 10
        run_conv(32'hFFFFFFFF, 1'b0, "umax");
        check("umax bcd",   70'(bcd8),  70'(40'h4294967295));
        check("umax ovf8",  70'(ovf8),  70'(1'b1));
        check("umax seg8",  70'(seg8),  70'({8{7'h3F}}));
        check("umax ovf10", 70'(ovf10), 70'(1'b0));
        check("umax seg10", 70'(seg10),
              70'({7'h19, 7'h24, 7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}));
        end_conv("umax");

        // -2147483648: 10 digits + sign overflows even 10 displays
        run_conv(32'h80000000, 1'b1, "smin");
        check("smin bcd10", 70'(bcd10), 70'(40'h2147483648));
        check("smin neg10", 70'(neg10), 70'(1'b1));
        check("smin ovf10", 70'(ovf10), 70'(1'b1));
        check("smin seg10", 70'(seg10), 70'({10{7'h3F}}));
        end_conv("smin");

        // -9999999: seven digits plus sign exactly fill 8 displays
        d = -32'd9999999;
        run_conv(d, 1'b1, "m9999999");
        check("m9999999 bcd",   70'(bcd8),  70'(40'h0009999999));
        check("m9999999 ovf8",  70'(ovf8),  70'(1'b0));
        check("m9999999 seg8",  70'(seg8),  70'({7'h3F, {7{7'h10}}}));
        check("m9999999 seg10", 70'(seg10), 70'({7'h7F, 7'h7F, 7'h3F, {7{7'h10}}}));
        end_conv("m9999999");

        // -10000000: eight digits plus sign, one too many for 8 displays
        d = -32'd10000000;
        run_conv(d, 1'b1, "m1e7");
        check("m1e7 ovf8",  70'(ovf8),  70'(1'b1));
        check("m1e7 ovf10", 70'(ovf10), 70'(1'b0));
        end_conv("m1e7");

        // Zero with signed_mode: units shows 0, rest blank
        run_conv(32'd0, 1'b1, "zero");
        check("zero seg8", 70'(seg8), 70'({{7{7'h7F}}, 7'h40}));
        check("zero neg",  70'(neg8), 70'(1'b0));
        end_conv("zero");

        // Pending slot: 7 at t, 8 at t+5, 9 at t+10; 9 overwrites 8
        start_req(32'd7, 1'b0);
        wait_edges(4);
        start_req(32'd8, 1'b0);
        wait_edges(4);
        start_req(32'd9, 1'b0);
        wait_edges(22);
        check("pend done before t+33", 70'(done8), 70'(1'b0));
        wait_edges(1);
        check("pend done t+33", 70'(done8), 70'(1'b1));
        check("pend bcd 7",     70'(bcd8),  70'(40'h7));
        check("pend busy held", 70'(busy8), 70'(1'b1));
        bad = 1'b0;
        for (int i = 34; i < 66; i++) begin
            wait_edges(1);
            if (done8 !== 1'b0 || bcd8 !== 40'h7 || busy8 !== 1'b1) bad = 1'b1;
        end
        check("pend hold t+34..t+65", 70'(bad), 70'(1'b0));
        wait_edges(1);
        check("pend done t+66", 70'(done8), 70'(1'b1));
        check("pend bcd 9",     70'(bcd8),  70'(40'h9));
        end_conv("pend");

        // Reset mid-conversion with a request pending
        start_req(32'd123, 1'b0);
        wait_edges(9);
        start_req(32'd55, 1'b0);
        wait_edges(9);
        #3;
        reset_n = 1'b0;
        #1;
        check("abort busy", 70'(busy8), 70'(1'b0));
        check("abort done", 70'(done8), 70'(1'b0));
        check("abort bcd",  70'(bcd8),  70'(40'h0));
        check("abort seg8", 70'(seg8),  70'({{7{7'h7F}}, 7'h40}));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_edges(1);
            if (done8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
        end
        check("abort no done/pending", 70'(bad), 70'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bcd_display_driver
`default_nettype wire
